tod_ts_capture: RTL and testbench
=================================

TOD_TS_CAPTURE -- requirements
Module: tod_ts_capture

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of event-trigger channels (1..16).
REQ-002 SHALL have parameter CLK_PERIOD_NS, default 8, nanosecond increment per clock.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, record FIFO depth (power of 2, >=2).
REQ-004 SHALL have parameter FREERUN, default 1; 1 = wrap second without PPS, 0 = saturate nanoseconds.
REQ-005 SHALL have port clk_125m  in  1  sole clock; one clock; reset is synchronous and active-high.
REQ-006 SHALL have port rst  in  1  synchronous active-high reset.
REQ-007 SHALL have port pps_in  in  1  asynchronous PPS pulse.
REQ-008 SHALL have port tod_sec_in  in  32  decoded TOD week-second, stable around the PPS edge.
REQ-009 SHALL have port trig_in  in  NUM_CH  asynchronous per-channel event inputs.
REQ-010 SHALL have port ts_vld  out  1  head record valid.
REQ-011 SHALL have port ts_rdy  in  1  consumer accepts head record.
REQ-012 SHALL have port ts_ch  out  4  channel index of head record.
REQ-013 SHALL have port ts_sec  out  32  week-second of head record.
REQ-014 SHALL have port ts_nano_sec  out  32  nanoseconds of head record.
REQ-015 SHALL have port ts_checksum  out  8  checksum of head record.
REQ-016 SHALL have port fifo_level  out  $clog2(FIFO_DEPTH)+1  records stored.
REQ-017 SHALL have port ovf_cnt  out  16  dropped-event count, saturating at 0xFFFF.
REQ-018 SHALL have port pps_lost  out  1  high while timebase runs without PPS.

Function
REQ-019 SHALL synchronise pps_in and each trig_in bit through two flops; a rising edge is detected when the second-stage flop is 1 and a third-stage flop is 0.
REQ-020 SHALL on PPS edge set nano_sec to 0, load sec_cnt from tod_sec_in, and clear pps_lost in the same cycle.
REQ-021 SHALL otherwise add CLK_PERIOD_NS to nano_sec each cycle while nano_sec < 1_000_000_000 - CLK_PERIOD_NS.
REQ-022 SHALL at nano_sec = 1_000_000_000 - CLK_PERIOD_NS without PPS edge: FREERUN=1 -> nano_sec to 0, sec_cnt +1 (mod 2^32), pps_lost to 1; FREERUN=0 -> hold nano_sec, sec_cnt unchanged, pps_lost to 1.
REQ-023 SHALL on a channel edge latch {sec_cnt, nano_sec} as held in that cycle into the channel's capture register and set its pending flag.
REQ-024 SHALL, when an edge arrives on a channel whose pending flag is already set, discard the new edge, keep the old capture and increment ovf_cnt by 1.
REQ-025 SHALL, when several channels raise ovf events in the same cycle, add the number of events to ovf_cnt, saturating at 0xFFFF.
REQ-026 SHALL each cycle with FIFO not full move the pending channel of lowest index into the FIFO and clear its flag; at most one record per cycle.
REQ-027 SHALL, when the FIFO is full, keep pending flags set (no drop) until space frees.
REQ-028 SHALL compute the checksum as the 8-bit modulo-256 sum of the 4 bytes of sec, the 4 bytes of nano_sec and zero-extended channel index, registered before FIFO write.
REQ-029 SHALL give minimum latency of 3 cycles from detected edge to ts_vld high with an empty FIFO (capture, checksum, write).
REQ-030 SHALL pop the head when ts_vld and ts_rdy are both high; ts_* hold stable while ts_vld=1 and ts_rdy=0.
REQ-031 SHALL allow simultaneous push and pop when full or empty-with-write; fifo_level unchanged on simultaneous push and pop.
REQ-032 SHALL wrap FIFO pointers modulo FIFO_DEPTH; fifo_level ranges 0..FIFO_DEPTH.
REQ-033 SHALL give a PPS edge and a channel edge in the same cycle a capture of sec = tod_sec_in, nano_sec = 0.

Reset
REQ-034 SHALL on rst=1 clear nano_sec, sec_cnt, all sync flops, pending flags, FIFO pointers, fifo_level, ovf_cnt, ts_vld, ts_ch, ts_sec, ts_nano_sec, ts_checksum to 0 and pps_lost to 0.
REQ-035 SHALL discard records and pending captures when rst asserts mid-operation; first post-reset edge is processed normally.

Verification
REQ-036 SHALL cover: PPS with tod_sec_in=0x12345678, trig ch2 1000 cycles later -> record ch=2, sec=0x12345678, nano=8000 (minus sync offset as computed), checksum matches byte sum.
REQ-037 SHALL cover: trig on ch0 and ch3 same cycle, ts_rdy=1 -> ch0 record then ch3 record on consecutive cycles, identical timestamps.
REQ-038 SHALL cover: ts_rdy=0, 17 events (FIFO_DEPTH=16) on one channel spaced apart -> fifo_level=16, one pending held, further edge increments ovf_cnt to 1.
REQ-039 SHALL cover: no PPS for 1.5 s, FREERUN=1 -> nano wraps to 0, sec_cnt +1, pps_lost=1; next PPS clears pps_lost.
REQ-040 SHALL cover: FREERUN=0, no PPS -> nano_sec holds 999_999_992, sec_cnt unchanged.
REQ-041 SHALL cover: rst pulse with 5 records stored -> ts_vld=0, fifo_level=0, ovf_cnt=0 next cycle.

Source files
------------

// File: rtl/tod_ts_capture.sv
// Time-of-day timestamp capture: PPS-disciplined second/nanosecond timebase,
// per-channel event capture with overflow counting, checksum stage and record FIFO.
module tod_ts_capture #(
    parameter int unsigned NUM_CH        = 4,
    parameter int unsigned CLK_PERIOD_NS = 8,
    parameter int unsigned FIFO_DEPTH    = 16,
    parameter int unsigned FREERUN       = 1
) (
    input  logic                        clk_125m,
    input  logic                        rst,
    input  logic                        pps_in,
    input  logic [31:0]                 tod_sec_in,
    input  logic [NUM_CH-1:0]           trig_in,
    output logic                        ts_vld,
    input  logic                        ts_rdy,
    output logic [3:0]                  ts_ch,
    output logic [31:0]                 ts_sec,
    output logic [31:0]                 ts_nano_sec,
    output logic [7:0]                  ts_checksum,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [15:0]                 ovf_cnt,
    output logic                        pps_lost
);

    localparam int unsigned AW      = $clog2(FIFO_DEPTH);
    localparam int unsigned RW      = 4 + 32 + 32 + 8;
    localparam logic [31:0] NS_LAST = 32'(1_000_000_000 - CLK_PERIOD_NS);
    localparam logic [31:0] NS_STEP = 32'(CLK_PERIOD_NS);

    logic              pps_s1_q, pps_s2_q, pps_s3_q, pps_s1_d, pps_s2_d, pps_s3_d;
    logic [NUM_CH-1:0] trig_s1_q, trig_s2_q, trig_s3_q, trig_s1_d, trig_s2_d, trig_s3_d;
    logic              pps_edge;
    logic [NUM_CH-1:0] trig_edge;

    logic [31:0] nano_q, nano_d, sec_q, sec_d;
    logic        pps_lost_q, pps_lost_d;

    logic [31:0]       cap_sec_q  [NUM_CH];
    logic [31:0]       cap_sec_d  [NUM_CH];
    logic [31:0]       cap_nano_q [NUM_CH];
    logic [31:0]       cap_nano_d [NUM_CH];
    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [15:0]       ovf_q, ovf_d;
    logic [4:0]        ovf_inc;
    logic [16:0]       ovf_sum;
    logic [31:0]       snap_sec, snap_nano;
    logic              sel_vld, move;
    logic [3:0]        sel_idx;
    logic [AW+1:0]     occ;

    logic        stg_vld_q, stg_vld_d;
    logic [3:0]  stg_ch_q, stg_ch_d;
    logic [31:0] stg_sec_q, stg_sec_d, stg_nano_q, stg_nano_d, sel_sec, sel_nano;
    logic [7:0]  stg_sum_q, stg_sum_d;

    logic [RW-1:0] mem_q [FIFO_DEPTH];
    logic [RW-1:0] head;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          push, pop;

    assign ts_vld = (level_q != '0);
    assign pop    = ts_vld && ts_rdy;
    assign push   = stg_vld_q;

    // Synchronisers, edge detection and the sec/nanosecond timebase.
    always_comb begin
        pps_s1_d   = pps_in;
        pps_s2_d   = pps_s1_q;
        pps_s3_d   = pps_s2_q;
        trig_s1_d  = trig_in;
        trig_s2_d  = trig_s1_q;
        trig_s3_d  = trig_s2_q;
        pps_edge   = pps_s2_q & ~pps_s3_q;
        trig_edge  = trig_s2_q & ~trig_s3_q;
        nano_d     = nano_q;
        sec_d      = sec_q;
        pps_lost_d = pps_lost_q;
        if (pps_edge) begin
            nano_d     = '0;
            sec_d      = tod_sec_in;
            pps_lost_d = 1'b0;
        end else if (nano_q < NS_LAST) begin
            nano_d = nano_q + NS_STEP;
        end else begin
            pps_lost_d = 1'b1;
            if (FREERUN != 0) begin
                nano_d = '0;
                sec_d  = sec_q + 32'd1;
            end
        end
    end

    // Per-channel capture, pending flags, overflow count and lowest-index drain.
    always_comb begin
        sel_vld = 1'b0;
        sel_idx = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (!sel_vld && pend_q[i]) begin
                sel_vld = 1'b1;
                sel_idx = 4'(i);
            end
        end
        // Room counts the record already in the checksum stage and any pop this cycle.
        occ  = {1'b0, level_q} + (AW + 2)'(stg_vld_q) - (AW + 2)'(pop);
        move = sel_vld && (occ < (AW + 2)'(FIFO_DEPTH));
        // A PPS edge in the same cycle as a trigger is already reflected in the snapshot.
        snap_sec   = pps_edge ? tod_sec_in : sec_q;
        snap_nano  = pps_edge ? '0 : nano_q;
        pend_d     = pend_q;
        cap_sec_d  = cap_sec_q;
        cap_nano_d = cap_nano_q;
        ovf_inc    = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (move && (sel_idx == 4'(i))) pend_d[i] = 1'b0;
            if (trig_edge[i]) begin
                if (pend_q[i]) begin
                    ovf_inc = ovf_inc + 5'd1;
                end else begin
                    pend_d[i]     = 1'b1;
                    cap_sec_d[i]  = snap_sec;
                    cap_nano_d[i] = snap_nano;
                end
            end
        end
        ovf_sum = {1'b0, ovf_q} + 17'(ovf_inc);
        ovf_d   = ovf_sum[16] ? 16'hFFFF : ovf_sum[15:0];
    end

    // Checksum stage fed by the selected channel, then FIFO pointer/level update.
    always_comb begin
        sel_sec  = '0;
        sel_nano = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (sel_idx == 4'(i)) begin
                sel_sec  = cap_sec_q[i];
                sel_nano = cap_nano_q[i];
            end
        end
        stg_vld_d  = move;
        stg_ch_d   = stg_ch_q;
        stg_sec_d  = stg_sec_q;
        stg_nano_d = stg_nano_q;
        stg_sum_d  = stg_sum_q;
        if (move) begin
            stg_ch_d   = sel_idx;
            stg_sec_d  = sel_sec;
            stg_nano_d = sel_nano;
            stg_sum_d  = sel_sec[7:0] + sel_sec[15:8] + sel_sec[23:16] + sel_sec[31:24]
                       + sel_nano[7:0] + sel_nano[15:8] + sel_nano[23:16] + sel_nano[31:24]
                       + {4'b0, sel_idx};
        end
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q + (AW + 1)'(push) - (AW + 1)'(pop);
    end

    // State register with synchronous reset.
    always_ff @(posedge clk_125m) begin
        if (rst) begin
            pps_s1_q   <= 1'b0;
            pps_s2_q   <= 1'b0;
            pps_s3_q   <= 1'b0;
            trig_s1_q  <= '0;
            trig_s2_q  <= '0;
            trig_s3_q  <= '0;
            nano_q     <= '0;
            sec_q      <= '0;
            pps_lost_q <= 1'b0;
            cap_sec_q  <= '{default: '0};
            cap_nano_q <= '{default: '0};
            pend_q     <= '0;
            ovf_q      <= '0;
            stg_vld_q  <= 1'b0;
            stg_ch_q   <= '0;
            stg_sec_q  <= '0;
            stg_nano_q <= '0;
            stg_sum_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
        end else begin
            pps_s1_q   <= pps_s1_d;
            pps_s2_q   <= pps_s2_d;
            pps_s3_q   <= pps_s3_d;
            trig_s1_q  <= trig_s1_d;
            trig_s2_q  <= trig_s2_d;
            trig_s3_q  <= trig_s3_d;
            nano_q     <= nano_d;
            sec_q      <= sec_d;
            pps_lost_q <= pps_lost_d;
            cap_sec_q  <= cap_sec_d;
            cap_nano_q <= cap_nano_d;
            pend_q     <= pend_d;
            ovf_q      <= ovf_d;
            stg_vld_q  <= stg_vld_d;
            stg_ch_q   <= stg_ch_d;
            stg_sec_q  <= stg_sec_d;
            stg_nano_q <= stg_nano_d;
            stg_sum_q  <= stg_sum_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
        end
    end

    // Record storage; contents are don't-care until written.
    always_ff @(posedge clk_125m) begin
        if (push) mem_q[wr_ptr_q] <= {stg_ch_q, stg_sec_q, stg_nano_q, stg_sum_q};
    end

    assign head        = mem_q[rd_ptr_q];
    assign ts_ch       = ts_vld ? head[75:72] : '0;
    assign ts_sec      = ts_vld ? head[71:40] : '0;
    assign ts_nano_sec = ts_vld ? head[39:8]  : '0;
    assign ts_checksum = ts_vld ? head[7:0]   : '0;
    assign fifo_level  = level_q;
    assign ovf_cnt     = ovf_q;
    assign pps_lost    = pps_lost_q;

endmodule

// File: tb/tb_tod_ts_capture.sv
// Bench for tod_ts_capture: one default-timing instance for capture/FIFO behaviour,
// plus free-running and saturating instances with a 20 ms clock period (50 clocks per
// second) so that second rollover happens within a short run.
module tb_tod_ts_capture;

    typedef struct packed {
        logic [3:0]  ch;
        logic [31:0] sec;
        logic [31:0] nano;
    } rec_t;

    logic clk = 1'b0;
    always #4 clk = ~clk;

    logic rst;

    logic        pps_a, rdy_a, vld_a, lost_a;
    logic [31:0] tod_a, sec_a, nano_a;
    logic [3:0]  trig_a, ch_a;
    logic [7:0]  sum_a;
    logic [4:0]  level_a;
    logic [15:0] ovf_a;

    logic        pps_b;
    logic [31:0] tod_b;
    logic [0:0]  trig_b;
    logic        fr_vld, fr_lost, sat_vld, sat_lost;
    logic [3:0]  fr_ch, sat_ch;
    logic [31:0] fr_sec, fr_nano, sat_sec, sat_nano;
    logic [7:0]  fr_sum, sat_sum;
    logic [4:0]  fr_level, sat_level;
    logic [15:0] fr_ovf, sat_ovf;

    tod_ts_capture #(.NUM_CH(4), .CLK_PERIOD_NS(8), .FIFO_DEPTH(16), .FREERUN(1)) dut (
        .clk_125m(clk), .rst(rst), .pps_in(pps_a), .tod_sec_in(tod_a), .trig_in(trig_a),
        .ts_vld(vld_a), .ts_rdy(rdy_a), .ts_ch(ch_a), .ts_sec(sec_a), .ts_nano_sec(nano_a),
        .ts_checksum(sum_a), .fifo_level(level_a), .ovf_cnt(ovf_a), .pps_lost(lost_a)
    );

    tod_ts_capture #(.NUM_CH(1), .CLK_PERIOD_NS(20_000_000), .FIFO_DEPTH(16), .FREERUN(1)) u_fr (
        .clk_125m(clk), .rst(rst), .pps_in(pps_b), .tod_sec_in(tod_b), .trig_in(trig_b),
        .ts_vld(fr_vld), .ts_rdy(1'b1), .ts_ch(fr_ch), .ts_sec(fr_sec), .ts_nano_sec(fr_nano),
        .ts_checksum(fr_sum), .fifo_level(fr_level), .ovf_cnt(fr_ovf), .pps_lost(fr_lost)
    );

    tod_ts_capture #(.NUM_CH(1), .CLK_PERIOD_NS(20_000_000), .FIFO_DEPTH(16), .FREERUN(0)) u_sat (
        .clk_125m(clk), .rst(rst), .pps_in(pps_b), .tod_sec_in(tod_b), .trig_in(trig_b),
        .ts_vld(sat_vld), .ts_rdy(1'b1), .ts_ch(sat_ch), .ts_sec(sat_sec), .ts_nano_sec(sat_nano),
        .ts_checksum(sat_sum), .fifo_level(sat_level), .ovf_cnt(sat_ovf), .pps_lost(sat_lost)
    );

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   pps_a_cyc = 0;
    int   pps_b_cyc = 0;
    rec_t q_a[$], q_fr[$], q_sat[$];
    int   pop_cyc_a[$];
    rec_t exp_a, exp_fr, exp_sat;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] csum(input rec_t r);
        logic [7:0] s;
        s = '0;
        for (int i = 0; i < 4; i++) begin
            s = s + r.sec[8*i +: 8] + r.nano[8*i +: 8];
        end
        return s + {4'b0, r.ch};
    endfunction

    function automatic rec_t mk(input int ch, input logic [31:0] sec, input logic [31:0] nano);
        rec_t r;
        r.ch   = 4'(ch);
        r.sec  = sec;
        r.nano = nano;
        return r;
    endfunction

    // A trigger driven n clocks after the PPS pulse is detected n clocks after the PPS
    // edge; the counter reads 0 one clock after that edge, so it reads 8*(n-1) then.
    // n = 0 is the same-cycle case, which captures 0.
    function automatic logic [31:0] exp_nano_a(input int n);
        return (n == 0) ? 32'd0 : 32'(8 * (n - 1));
    endfunction

    // Scoreboard for the default instance: compare every accepted record.
    always @(negedge clk) begin
        if (rst === 1'b0 && vld_a === 1'b1 && rdy_a === 1'b1) begin
            checks++;
            if (q_a.size() == 0) begin
                errors++;
                $display("FAIL rec_a unexpected: got ch=%0d sec=%h nano=%0d", ch_a, sec_a, nano_a);
            end else begin
                exp_a = q_a.pop_front();
                if ({ch_a, sec_a, nano_a, sum_a} !== {exp_a.ch, exp_a.sec, exp_a.nano, csum(exp_a)}) begin
                    errors++;
                    $display("FAIL rec_a: got ch=%0d sec=%h nano=%0d sum=%h, expected ch=%0d sec=%h nano=%0d sum=%h",
                             ch_a, sec_a, nano_a, sum_a, exp_a.ch, exp_a.sec, exp_a.nano, csum(exp_a));
                end
            end
            pop_cyc_a.push_back(cyc);
        end
    end

    // Scoreboard for the free-running instance.
    always @(negedge clk) begin
        if (rst === 1'b0 && fr_vld === 1'b1) begin
            checks++;
            if (q_fr.size() == 0) begin
                errors++;
                $display("FAIL rec_fr unexpected: got sec=%0d nano=%0d", fr_sec, fr_nano);
            end else begin
                exp_fr = q_fr.pop_front();
                if ({fr_ch, fr_sec, fr_nano, fr_sum} !== {exp_fr.ch, exp_fr.sec, exp_fr.nano, csum(exp_fr)}) begin
                    errors++;
                    $display("FAIL rec_fr: got ch=%0d sec=%0d nano=%0d sum=%h, expected ch=%0d sec=%0d nano=%0d sum=%h",
                             fr_ch, fr_sec, fr_nano, fr_sum, exp_fr.ch, exp_fr.sec, exp_fr.nano, csum(exp_fr));
                end
            end
        end
    end

    // Scoreboard for the saturating instance.
    always @(negedge clk) begin
        if (rst === 1'b0 && sat_vld === 1'b1) begin
            checks++;
            if (q_sat.size() == 0) begin
                errors++;
                $display("FAIL rec_sat unexpected: got sec=%0d nano=%0d", sat_sec, sat_nano);
            end else begin
                exp_sat = q_sat.pop_front();
                if ({sat_ch, sat_sec, sat_nano, sat_sum} !== {exp_sat.ch, exp_sat.sec, exp_sat.nano, csum(exp_sat)}) begin
                    errors++;
                    $display("FAIL rec_sat: got ch=%0d sec=%0d nano=%0d sum=%h, expected ch=%0d sec=%0d nano=%0d sum=%h",
                             sat_ch, sat_sec, sat_nano, sat_sum, exp_sat.ch, exp_sat.sec, exp_sat.nano, csum(exp_sat));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pps_a_pulse(input logic [31:0] tod);
        tod_a     = tod;
        pps_a     = 1'b1;
        pps_a_cyc = cyc;
        tick(2);
        pps_a     = 1'b0;
    endtask

    task automatic goto_a(input int n);
        if (cyc - pps_a_cyc < n) tick(n - (cyc - pps_a_cyc));
    endtask

    task automatic goto_b(input int n);
        if (cyc - pps_b_cyc < n) tick(n - (cyc - pps_b_cyc));
    endtask

    task automatic trig_a_at(input int n, input logic [3:0] mask, input bit push);
        goto_a(n);
        if (push) begin
            for (int i = 0; i < 4; i++) begin
                if (mask[i]) q_a.push_back(mk(i, tod_a, exp_nano_a(n)));
            end
        end
        trig_a = mask;
        tick(2);
        trig_a = '0;
    endtask

    task automatic drain(input int max);
        int k;
        k = 0;
        while ((q_a.size() + q_fr.size() + q_sat.size()) != 0 && k < max) begin
            tick(1);
            k++;
        end
        checks++;
        if ((q_a.size() + q_fr.size() + q_sat.size()) != 0) begin
            errors++;
            $display("FAIL drain: records outstanding a=%0d fr=%0d sat=%0d, expected 0",
                     q_a.size(), q_fr.size(), q_sat.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; pps_a = 1'b0; tod_a = '0; trig_a = '0; rdy_a = 1'b0;
        pps_b = 1'b0; tod_b = '0; trig_b = '0;
        tick(4);
        checks++;
        if ({vld_a, level_a, ovf_a, lost_a} !== '0) begin
            errors++;
            $display("FAIL reset_status: got vld=%b level=%0d ovf=%0d lost=%b, expected all 0",
                     vld_a, level_a, ovf_a, lost_a);
        end
        checks++;
        if ({ch_a, sec_a, nano_a, sum_a} !== '0) begin
            errors++;
            $display("FAIL reset_head: got ch=%0d sec=%h nano=%h sum=%h, expected all 0",
                     ch_a, sec_a, nano_a, sum_a);
        end
        checks++;
        if ({fr_vld, fr_lost, sat_vld, sat_lost} !== 4'b0) begin
            errors++;
            $display("FAIL reset_b: got fr_vld=%b fr_lost=%b sat_vld=%b sat_lost=%b, expected 0",
                     fr_vld, fr_lost, sat_vld, sat_lost);
        end
        rst = 1'b0;
        tick(2);
    endtask

    task automatic test_pps_capture();
        int c;
        rdy_a = 1'b0;
        pps_a_pulse(32'h12345678);
        goto_a(1000);
        q_a.push_back(mk(2, 32'h12345678, exp_nano_a(1000)));
        trig_a = 4'b0100;
        c = cyc;
        tick(2);
        trig_a = '0;
        tick(2);
        checks++;
        if (vld_a !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: ts_vld=%b at edge+%0d, expected 0", vld_a, cyc - c);
        end
        tick(1);
        checks++;
        if (vld_a !== 1'b1 || level_a !== 5'd1) begin
            errors++;
            $display("FAIL latency_valid: ts_vld=%b level=%0d at edge+%0d, expected 1 and 1",
                     vld_a, level_a, cyc - c);
        end
        checks++;
        if (lost_a !== 1'b0) begin
            errors++;
            $display("FAIL pps_lost_a: got %b, expected 0", lost_a);
        end
        rdy_a = 1'b1;
        drain(50);
    endtask

    task automatic test_same_cycle();
        int n;
        rdy_a = 1'b1;
        pop_cyc_a.delete();
        pps_a_pulse(32'hCAFE0001);
        trig_a_at(40, 4'b1001, 1);
        drain(50);
        n = pop_cyc_a.size();
        checks++;
        if (n != 2 || (pop_cyc_a[n-1] - pop_cyc_a[n-2]) != 1) begin
            errors++;
            $display("FAIL back_to_back: got %0d pops, spacing %0d, expected 2 pops spaced 1",
                     n, (n >= 2) ? pop_cyc_a[n-1] - pop_cyc_a[n-2] : -1);
        end
        tick(6);
        // PPS and trigger launched together: capture takes the new second and zero ns.
        tod_a  = 32'h0BADF00D;
        q_a.push_back(mk(1, 32'h0BADF00D, 32'd0));
        pps_a  = 1'b1;
        trig_a = 4'b0010;
        pps_a_cyc = cyc;
        tick(2);
        pps_a  = 1'b0;
        trig_a = '0;
        drain(50);
    endtask

    task automatic test_fifo_full();
        rec_t r17;
        rdy_a = 1'b0;
        pps_a_pulse(32'h00000777);
        for (int k = 0; k < 16; k++) trig_a_at(10 + 8 * k, 4'b0010, 1);
        r17 = mk(1, 32'h00000777, exp_nano_a(138));
        trig_a_at(138, 4'b0010, 0);
        goto_a(145);
        checks++;
        if (level_a !== 5'd16 || ovf_a !== 16'd0 || vld_a !== 1'b1) begin
            errors++;
            $display("FAIL fifo_full: got level=%0d ovf=%0d vld=%b, expected 16 0 1", level_a, ovf_a, vld_a);
        end
        trig_a_at(146, 4'b0010, 0);
        goto_a(152);
        checks++;
        if (ovf_a !== 16'd1) begin
            errors++;
            $display("FAIL ovf_single: got %0d, expected 1", ovf_a);
        end
        // Held channel 1 drains after channel 0 (lowest index first), despite being older.
        q_a.push_back(mk(0, 32'h00000777, exp_nano_a(154)));
        q_a.push_back(r17);
        q_a.push_back(mk(2, 32'h00000777, exp_nano_a(154)));
        q_a.push_back(mk(3, 32'h00000777, exp_nano_a(154)));
        trig_a_at(154, 4'b1111, 0);
        goto_a(160);
        checks++;
        if (ovf_a !== 16'd2 || level_a !== 5'd16) begin
            errors++;
            $display("FAIL ovf_partial: got ovf=%0d level=%0d, expected 2 16", ovf_a, level_a);
        end
        trig_a_at(162, 4'b1111, 0);
        goto_a(168);
        checks++;
        if (ovf_a !== 16'd6) begin
            errors++;
            $display("FAIL ovf_multi: got %0d, expected 6", ovf_a);
        end
        rdy_a = 1'b1;
        drain(100);
        tick(2);
        checks++;
        if (level_a !== 5'd0 || vld_a !== 1'b0 || ovf_a !== 16'd6) begin
            errors++;
            $display("FAIL fifo_empty: got level=%0d vld=%b ovf=%0d, expected 0 0 6", level_a, vld_a, ovf_a);
        end
    endtask

    task automatic test_freerun();
        // 50 clocks per second: counter reaches 980_000_000 at 49 clocks past the load,
        // then wraps (free-running) or holds there (saturating).
        tod_b = 32'd100;
        pps_b = 1'b1;
        pps_b_cyc = cyc;
        tick(2);
        pps_b = 1'b0;
        goto_b(20);
        checks++;
        if (fr_lost !== 1'b0 || sat_lost !== 1'b0) begin
            errors++;
            $display("FAIL lost_after_pps: got fr=%b sat=%b, expected 0 0", fr_lost, sat_lost);
        end
        goto_b(30);
        q_fr.push_back(mk(0, 32'd100, 32'd580_000_000));
        q_sat.push_back(mk(0, 32'd100, 32'd580_000_000));
        trig_b = 1'b1; tick(2); trig_b = 1'b0;
        goto_b(60);
        q_fr.push_back(mk(0, 32'd101, 32'd180_000_000));
        q_sat.push_back(mk(0, 32'd100, 32'd980_000_000));
        trig_b = 1'b1; tick(2); trig_b = 1'b0;
        goto_b(75);
        checks++;
        if (fr_lost !== 1'b1 || sat_lost !== 1'b1) begin
            errors++;
            $display("FAIL lost_no_pps: got fr=%b sat=%b, expected 1 1", fr_lost, sat_lost);
        end
        tod_b = 32'd300;
        pps_b = 1'b1;
        pps_b_cyc = cyc;
        tick(2);
        pps_b = 1'b0;
        tick(4);
        checks++;
        if (fr_lost !== 1'b0 || sat_lost !== 1'b0) begin
            errors++;
            $display("FAIL lost_cleared: got fr=%b sat=%b, expected 0 0", fr_lost, sat_lost);
        end
        drain(50);
    endtask

    task automatic test_reset_mid();
        rdy_a = 1'b0;
        pps_a_pulse(32'd1);
        for (int k = 0; k < 5; k++) trig_a_at(10 + 8 * k, 4'b0100, 1);
        goto_a(60);
        checks++;
        if (level_a !== 5'd5) begin
            errors++;
            $display("FAIL level_before_rst: got %0d, expected 5", level_a);
        end
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        q_a.delete();
        checks++;
        if (vld_a !== 1'b0 || level_a !== 5'd0 || ovf_a !== 16'd0 || lost_a !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got vld=%b level=%0d ovf=%0d lost=%b, expected 0 0 0 0",
                     vld_a, level_a, ovf_a, lost_a);
        end
        tick(3);
        rdy_a = 1'b1;
        pps_a_pulse(32'h00000055);
        trig_a_at(20, 4'b1000, 1);
        drain(50);
    endtask

    initial begin
        test_reset();
        test_pps_capture();
        test_same_cycle();
        test_fifo_full();
        test_freerun();
        test_reset_mid();
        tick(5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
